// File: rtl/pixel_frame_streamer.sv
// Raster-order frame reader: walks a synchronous-read image memory and emits
// a valid/ready pixel stream with coordinates and SOF/EOL/EOF markers through a 3-entry FIFO.
module pixel_frame_streamer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 4,
    parameter int unsigned BITW   = 8,
    parameter int unsigned ADDRW  = 5,
    parameter int unsigned XW     = 3,
    parameter int unsigned YW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic [ADDRW-1:0] mem_addr,
    input  logic [BITW-1:0]  mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITW-1:0]  out_pixel,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof
);

    localparam int unsigned DEPTH = 3;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [BITW-1:0] pixel;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic            sof;
        logic            eol;
        logic            eof;
    } entry_t;

    state_t         state_q;
    logic [XW-1:0]  rd_x_q;
    logic [YW-1:0]  rd_y_q;
    logic [XW-1:0]  cap_x_q;
    logic [YW-1:0]  cap_y_q;
    logic           inflight_q;
    logic           busy_q;
    logic           done_q;
    entry_t         fifo_q [DEPTH];
    entry_t         fifo_d [DEPTH];
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    entry_t         push_entry;
    logic           pop;
    logic           last_rd;

    // Head of the FIFO drives the stream; entry 0 keeps its value once drained.
    assign out_valid = (count_q != 2'd0);
    assign out_pixel = fifo_q[0].pixel;
    assign out_x     = fifo_q[0].x;
    assign out_y     = fifo_q[0].y;
    assign out_sof   = fifo_q[0].sof;
    assign out_eol   = fifo_q[0].eol;
    assign out_eof   = fifo_q[0].eof;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        pop      = out_valid && out_ready;
        mem_en   = (state_q == STREAM) && ((3'(count_q) + 3'(inflight_q)) < 3'(DEPTH));
        mem_addr = ADDRW'(32'(rd_y_q) * WIDTH + 32'(rd_x_q));
        last_rd  = (rd_x_q == XW'(WIDTH - 1)) && (rd_y_q == YW'(HEIGHT - 1));

        push_entry.pixel = mem_rdata;
        push_entry.x     = cap_x_q;
        push_entry.y     = cap_y_q;
        push_entry.sof   = (cap_x_q == '0) && (cap_y_q == '0);
        push_entry.eol   = (cap_x_q == XW'(WIDTH - 1));
        push_entry.eof   = (cap_x_q == XW'(WIDTH - 1)) && (cap_y_q == YW'(HEIGHT - 1));

        fifo_d  = fifo_q;
        count_d = count_q;
        // Pop shifts valid entries toward the head, then the returning read lands at the tail.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (2'(i + 1) < count_q) begin
                    fifo_d[i] = fifo_q[i + 1];
                end
            end
            count_d = count_q - 2'd1;
        end
        if (inflight_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (2'(i) == count_d) begin
                    fifo_d[i] = push_entry;
                end
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            cap_x_q    <= '0;
            cap_y_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            inflight_q <= mem_en;
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            if (mem_en) begin
                cap_x_q <= rd_x_q;
                cap_y_q <= rd_y_q;
                if (rd_x_q == XW'(WIDTH - 1)) begin
                    rd_x_q <= '0;
                    rd_y_q <= (rd_y_q == YW'(HEIGHT - 1)) ? '0 : rd_y_q + YW'(1);
                end else begin
                    rd_x_q <= rd_x_q + XW'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        busy_q  <= 1'b1;
                        rd_x_q  <= '0;
                        rd_y_q  <= '0;
                    end
                end
                STREAM: begin
                    if (mem_en && last_rd) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && fifo_q[0].eof) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench for pixel_frame_streamer: frame-level reference model (raster index, outstanding
// reads, handshakes) checked every cycle, plus literal checks for latency and markers.
module tb_pixel_frame_streamer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HEIGHT = 4;
    localparam int unsigned BITW   = 8;
    localparam int unsigned ADDRW  = 5;
    localparam int unsigned XW     = 3;
    localparam int unsigned YW     = 2;
    localparam int          NPIX   = WIDTH * HEIGHT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             mem_en;
    logic [ADDRW-1:0] mem_addr;
    logic [BITW-1:0]  mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [BITW-1:0]  out_pixel;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;

    pixel_frame_streamer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BITW(BITW), .ADDRW(ADDRW), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    logic [BITW-1:0] tb_mem [NPIX];
    always @(posedge clk) if (mem_en) mem_rdata <= tb_mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: frame progress in pixels and reads
    bit   mbusy = 0, last_issue = 0, exp_done = 0, exp_en = 0, hs = 0, start_acc = 0;
    bit   prev_stall = 0, sof_seen = 0;
    int   idx = 0, issued = 0, landed = 0, frames = 0, done_pulses = 0;
    int   obs_issued = 0, obs_hs = 0;
    int   first_valid_cyc = -1, done_cyc = -1, last_done_cyc = -1000, sof_gap = -1;
    int   valid_cycles = 0, eol_cnt = 0, eol_sum = 0, sof_idx = -1, eof_idx = -1;
    logic [15:0] prev_pay = '0;
    logic [BITW-1:0] got [$];

    always @(negedge clk) begin
        #2;
        if (rst) begin
            mbusy = 0; idx = 0; issued = 0; last_issue = 0; exp_done = 0;
            obs_issued = 0; obs_hs = 0; prev_stall = 0;
        end else begin
            chk("busy", 32'(busy), 32'(mbusy));
            chk("done", 32'(done), 32'(exp_done));
            exp_en = mbusy && (issued < NPIX) && ((issued - idx) < 3);
            chk("mem_en", 32'(mem_en), 32'(exp_en));
            if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(issued));
            chk("fifo_count_le3", 32'((obs_issued - obs_hs) <= 3), 32'd1);
            landed = issued - (last_issue ? 1 : 0);
            chk("out_valid", 32'(out_valid), 32'(landed > idx));
            if (out_valid && landed > idx) begin
                chk("out_pixel", 32'(out_pixel), 32'(tb_mem[idx]));
                chk("out_xy", 32'({out_x, out_y}),
                    32'({XW'(idx % WIDTH), YW'(idx / WIDTH)}));
                chk("markers", 32'({out_sof, out_eol, out_eof}),
                    32'({idx == 0, (idx % WIDTH) == WIDTH - 1, idx == NPIX - 1}));
            end
            if (prev_stall)
                chk("stall_hold", 32'({out_valid, out_pixel, out_x, out_y, out_sof, out_eol, out_eof}),
                    32'({1'b1, prev_pay}));
            hs = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            prev_pay = {out_pixel, out_x, out_y, out_sof, out_eol, out_eof};
            if (done) begin done_pulses++; done_cyc = cyc; last_done_cyc = cyc; end
            if (out_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_sof && !sof_seen) begin sof_seen = 1; sof_gap = cyc - last_done_cyc; end
            end
            // Advance the model across the coming edge
            start_acc = !mbusy && start;
            if (mem_en) obs_issued++;
            if (hs) obs_hs++;
            last_issue = exp_en;
            if (exp_en) issued++;
            exp_done = 0;
            if (hs && mbusy) begin
                got.push_back(out_pixel);
                if (out_eol) begin eol_cnt++; eol_sum += idx; end
                if (out_sof) sof_idx = idx;
                if (out_eof) eof_idx = idx;
                if (idx == NPIX - 1) begin exp_done = 1; mbusy = 0; frames++; end
                idx++;
            end
            if (start_acc) begin
                mbusy = 1; idx = 0; issued = 0; last_issue = 0; got.delete();
                first_valid_cyc = -1; valid_cycles = 0; eol_cnt = 0; eol_sum = 0;
                sof_idx = -1; eof_idx = -1; sof_seen = 0;
            end
        end
    end

    int n_start = 0;

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        n_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input bit rand_ready);
        int t = 0;
        while (frames < target && t < 3000) begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        if (frames < target) chk("frame_timeout", 32'(frames), 32'(target));
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (got.size() < n) chk("pixel_timeout", 32'(got.size()), 32'(n));
    endtask

    function automatic int count_match();
        int m = 0;
        if (got.size() != NPIX) return -1;
        for (int i = 0; i < NPIX; i++) if (got[i] == tb_mem[i]) m++;
        return m;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) tb_mem[i] = BITW'($urandom);
    endtask

    int base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < NPIX; k++)
            tb_mem[k] = ((((k % WIDTH) / 2) + ((k / WIDTH) / 2)) % 2) != 0 ? 8'hFF : 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, mem_en, mem_addr, out_valid, out_pixel,
                                  out_x, out_y, out_sof, out_eol, out_eof}), 32'd0);
        #3 rst = 1'b0;

        // Checkerboard, continuous ready
        out_ready = 1'b1;
        start_frame();
        wait_frames(frames + 1, 0);
        repeat (3) @(negedge clk);
        chk("first_valid_latency", 32'(first_valid_cyc - n_start), 32'd2);
        chk("done_latency", 32'(done_cyc - n_start), 32'd34);
        chk("valid_cycles", 32'(valid_cycles), 32'd32);
        chk("cb_pix0", 32'(got[0]), 32'h00);
        chk("cb_pix2", 32'(got[2]), 32'hFF);
        chk("cb_pix17", 32'(got[17]), 32'hFF);
        chk("cb_pix31", 32'(got[31]), 32'h00);
        chk("eol_count", 32'(eol_cnt), 32'd4);
        chk("eol_index_sum", 32'(eol_sum), 32'd76);
        chk("sof_index", 32'(sof_idx), 32'd0);
        chk("eof_index", 32'(eof_idx), 32'd31);

        // Stalled from the start: three reads then hold
        fill_random();
        out_ready = 1'b0;
        base = obs_issued;
        start_frame();
        repeat (12) @(negedge clk);
        chk("stall_reads", 32'(obs_issued - base), 32'd3);
        chk("stall_mem_en", 32'(mem_en), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pixel0", 32'(out_pixel), 32'(tb_mem[0]));
        chk("stall_sof", 32'(out_sof), 32'd1);
        out_ready = 1'b1;
        wait_frames(frames + 1, 0);
        repeat (3) @(negedge clk);
        chk("stall_frame_data", 32'(count_match()), 32'(NPIX));

        // Random backpressure over three frames
        for (int f = 0; f < 3; f++) begin
            fill_random();
            start_frame();
            wait_frames(frames + 1, 1);
            out_ready = 1'b1;
            repeat (3) @(negedge clk);
            chk("rand_frame_data", 32'(count_match()), 32'(NPIX));
        end

        // start pulse while busy is ignored
        out_ready = 1'b1;
        base = done_pulses;
        start_frame();
        wait_got(5);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_frames(frames + 1, 0);
        repeat (10) @(negedge clk);
        chk("busy_start_done_pulses", 32'(done_pulses - base), 32'd1);
        chk("busy_start_pixels", 32'(got.size()), 32'(NPIX));
        chk("busy_start_idle", 32'(busy), 32'd0);

        // start held high: frames run back to back
        base = frames;
        @(negedge clk) start = 1'b1;
        wait_frames(base + 2, 0);
        chk("b2b_sof_after_done_cycle", 32'(sof_gap - 1), 32'd2);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_frames(base + 3, 0);
        repeat (3) @(negedge clk);
        chk("b2b_sof_gap_frame3", 32'(sof_gap - 1), 32'd2);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset mid-frame after the 10th handshake
        fill_random();
        start_frame();
        wait_got(10);
        base = done_pulses;
        @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("midrst_outputs", 32'({busy, done, mem_en, mem_addr, out_valid, out_pixel,
                                      out_x, out_y, out_sof, out_eol, out_eof}), 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_pulses - base), 32'd0);
        start_frame();
        wait_frames(frames + 1, 0);
        repeat (3) @(negedge clk);
        chk("midrst_restart_pix0", 32'(got[0]), 32'(tb_mem[0]));
        chk("midrst_restart_frame", 32'(count_match()), 32'(NPIX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
